// File: rtl/clk_div_bank.sv
// Bank of CHANNELS runtime-programmable clock dividers with shadowed config and shared sync.
// Optional strobe outputs are enabled by defining CLK_DIV_BANK_STROBE_EN.
module clk_div_bank #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 16,
  parameter int DEF_HALF = 1,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [CHANNELS-1:0] en_i,
  input  logic                sync_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [CW-1:0]       cfg_chan_i,
  input  logic [DIV_W-1:0]    cfg_high_i,
  input  logic [DIV_W-1:0]    cfg_low_i,
  output logic [CHANNELS-1:0] clk_o,
  output logic [CHANNELS-1:0] stb_o
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

  localparam logic [DIV_W-1:0] DEF_LEN = DIV_W'(DEF_HALF);
  localparam logic [DIV_W:0]   ONE     = (DIV_W+1)'(1);

  state_e              state_q  [CHANNELS];
  state_e              state_d  [CHANNELS];
  logic [DIV_W:0]      ctr_q    [CHANNELS];
  logic [DIV_W:0]      ctr_d    [CHANNELS];
  logic [DIV_W-1:0]    act_hi_q [CHANNELS];
  logic [DIV_W-1:0]    act_hi_d [CHANNELS];
  logic [DIV_W-1:0]    act_lo_q [CHANNELS];
  logic [DIV_W-1:0]    act_lo_d [CHANNELS];
  logic [DIV_W-1:0]    sh_hi_q  [CHANNELS];
  logic [DIV_W-1:0]    sh_hi_d  [CHANNELS];
  logic [DIV_W-1:0]    sh_lo_q  [CHANNELS];
  logic [DIV_W-1:0]    sh_lo_d  [CHANNELS];
  logic [DIV_W:0]      hi_eff   [CHANNELS];
  logic [DIV_W:0]      lo_eff   [CHANNELS];
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] clk_q, clk_d;
  logic [CHANNELS-1:0] accept, apply;

  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      hi_eff[c] = (act_hi_q[c] == '0) ? ONE : {1'b0, act_hi_q[c]};
      lo_eff[c] = (act_lo_q[c] == '0) ? ONE : {1'b0, act_lo_q[c]};
    end
  end

  // Out-of-range channel numbers match nothing: ready stays high and the write is dropped.
  always_comb begin
    cfg_ready_o = 1'b1;
    accept      = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (cfg_chan_i == CW'(c)) begin
        cfg_ready_o = ~pend_q[c];
        accept[c]   = cfg_valid_i & ~pend_q[c];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        state_q[c]  <= IDLE;
        ctr_q[c]    <= '0;
        act_hi_q[c] <= DEF_LEN;
        act_lo_q[c] <= DEF_LEN;
        sh_hi_q[c]  <= DEF_LEN;
        sh_lo_q[c]  <= DEF_LEN;
      end
      pend_q <= '0;
      clk_q  <= '0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        state_q[c]  <= state_d[c];
        ctr_q[c]    <= ctr_d[c];
        act_hi_q[c] <= act_hi_d[c];
        act_lo_q[c] <= act_lo_d[c];
        sh_hi_q[c]  <= sh_hi_d[c];
        sh_lo_q[c]  <= sh_lo_d[c];
      end
      pend_q <= pend_d;
      clk_q  <= clk_d;
    end
  end

  // A write accepted in the same cycle as an apply survives because accept is ORed in last.
  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      ctr_d[c]   = ctr_q[c];
      apply[c]   = 1'b0;
      if (sync_i) begin
        apply[c]   = pend_q[c];
        state_d[c] = en_i[c] ? HIGH : IDLE;
        ctr_d[c]   = en_i[c] ? ONE : '0;
      end else begin
        case (state_q[c])
          IDLE: begin
            apply[c] = pend_q[c];
            if (en_i[c]) begin
              state_d[c] = HIGH;
              ctr_d[c]   = ONE;
            end
          end
          HIGH: begin
            if (ctr_q[c] == hi_eff[c]) begin
              state_d[c] = LOW;
              ctr_d[c]   = ONE;
            end else begin
              ctr_d[c] = ctr_q[c] + ONE;
            end
          end
          LOW: begin
            if (ctr_q[c] == lo_eff[c]) begin
              apply[c]   = pend_q[c];
              state_d[c] = en_i[c] ? HIGH : IDLE;
              ctr_d[c]   = en_i[c] ? ONE : '0;
            end else begin
              ctr_d[c] = ctr_q[c] + ONE;
            end
          end
          default: begin
            state_d[c] = IDLE;
            ctr_d[c]   = '0;
          end
        endcase
      end
      act_hi_d[c] = apply[c] ? sh_hi_q[c] : act_hi_q[c];
      act_lo_d[c] = apply[c] ? sh_lo_q[c] : act_lo_q[c];
      sh_hi_d[c]  = accept[c] ? cfg_high_i : sh_hi_q[c];
      sh_lo_d[c]  = accept[c] ? cfg_low_i : sh_lo_q[c];
      pend_d[c]   = (pend_q[c] & ~apply[c]) | accept[c];
    end
  end

`ifdef CLK_DIV_BANK_STROBE_EN
  logic [CHANNELS-1:0] stb_q, stb_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) stb_q <= '0;
    else          stb_q <= stb_d;
  end

  assign stb_o = stb_q;
`else
  assign stb_o = '0;
`endif

  // Entering HIGH always loads ctr with one, so that marks every (re)started high phase.
  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      clk_d[c] = (state_d[c] == HIGH);
`ifdef CLK_DIV_BANK_STROBE_EN
      stb_d[c] = (state_d[c] == HIGH) && (ctr_d[c] == ONE);
`endif
    end
  end

  assign clk_o = clk_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: stimulus pushes hand-computed expectations into a
// scoreboard that a negedge monitor drains per cycle.
module tb_clk_div_bank;

  localparam int CH = 4;
  localparam int DW = 16;
`ifdef CLK_DIV_BANK_STROBE_EN
  localparam bit STB = 1'b1;
`else
  localparam bit STB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] en;
  logic          sync;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_chan;
  logic [DW-1:0] cfg_high, cfg_low;
  logic [CH-1:0] clk_out, stb;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      nm;
    int         at;
    int         kind;   // 0 clk_o, 1 cfg_ready_o, 2 stb_o
    logic [3:0] mask;
    logic [3:0] exp;
  } chk_t;

  chk_t sb[$];

  clk_div_bank #(.CHANNELS(CH), .DIV_W(DW), .DEF_HALF(1)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .en_i        (en),
    .sync_i      (sync),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_chan_i  (cfg_chan),
    .cfg_high_i  (cfg_high),
    .cfg_low_i   (cfg_low),
    .clk_o       (clk_out),
    .stb_o       (stb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int at, input string nm, input int kind,
                      input logic [3:0] mask, input logic [3:0] exp);
    chk_t e;
    e.nm = nm; e.at = at; e.kind = kind; e.mask = mask; e.exp = exp;
    sb.push_back(e);
  endtask

  // bits are listed oldest-first from the MSB end, one per cycle starting at 'start'.
  task automatic wave(input int start, input string nm, input int ch,
                      input logic [15:0] bits, input int n, input int kind);
    logic [3:0] m, e;
    for (int i = 0; i < n; i++) begin
      m = 4'b0001 << ch;
      e = {3'b000, bits[n-1-i]} << ch;
      push(start + i, nm, kind, m, e);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        case (sb[i].kind)
          0:       act = clk_out;
          1:       act = {3'b000, cfg_ready};
          default: act = stb;
        endcase
        n_cmp++;
        if (sb[i].at < cyc || (act & sb[i].mask) !== (sb[i].exp & sb[i].mask)) begin
          n_bad++;
          $display("FAIL %s @cyc %0d (due %0d): got %b expected %b mask %b",
                   sb[i].nm, cyc, sb[i].at, act, sb[i].exp, sb[i].mask);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = '0; sync = 1'b0; cfg_valid = 1'b0;
    cfg_chan = '0; cfg_high = '0; cfg_low = '0;

    goto(3);
    rst_n = 1'b1;
    push(3, "rst_clk", 0, 4'hF, 4'h0);
    push(3, "rst_rdy", 1, 4'h1, 4'h1);
    push(3, "rst_stb", 2, 4'hF, 4'h0);

    // Defaults 1/1: ch0 toggles every cycle, others stay low.
    en = 4'b0001;
    wave(4, "div2_ch0", 0, 16'b10101010, 8, 0);
    for (int i = 4; i < 12; i++) push(i, "div2_others", 0, 4'b1110, 4'b0000);
    wave(4, "div2_stb", 0, STB ? 16'b10101010 : 16'b0, 8, 2);

    // Reprogram running ch1 to 3/1.
    goto(11);
    en = 4'b0011;
    goto(12);
    cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_high = 16'd3; cfg_low = 16'd1;
    push(12, "h3_rdy_pre", 1, 4'h1, 4'h1);
    push(12, "h3_clk_pre", 0, 4'b0010, 4'b0010);
    goto(13);
    cfg_valid = 1'b0;
    push(13, "h3_rdy_pend", 1, 4'h1, 4'h0);
    push(13, "h3_clk_low", 0, 4'b0010, 4'b0000);
    push(14, "h3_rdy_free", 1, 4'h1, 4'h1);
    wave(14, "h3l1_ch1", 1, 16'b11101110, 8, 0);

    // 0/0 written in the period-end cycle; a second write while pending is refused.
    goto(21);
    cfg_valid = 1'b1; cfg_high = 16'd0; cfg_low = 16'd0;
    push(21, "h0_rdy_pe", 1, 4'h1, 4'h1);
    goto(22);
    cfg_high = 16'd7; cfg_low = 16'd7;
    push(22, "h0_rdy_block", 1, 4'h1, 4'h0);
    wave(22, "h0l0_ch1", 1, 16'b111010101010, 12, 0);
    goto(25);
    cfg_valid = 1'b0;
    push(26, "h0_rdy_after", 1, 4'h1, 4'h1);

    // ch2 at 4/4, enable dropped one cycle into HIGH.
    goto(33);
    cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_high = 16'd4; cfg_low = 16'd4;
    push(33, "dis_rdy_pre", 1, 4'h1, 4'h1);
    goto(34);
    cfg_valid = 1'b0;
    push(34, "dis_rdy_pend", 1, 4'h1, 4'h0);
    goto(35);
    en = 4'b0111;
    push(35, "dis_rdy_idle_apply", 1, 4'h1, 4'h1);
    wave(35, "dis_ch2", 2, 16'b0111100000000, 13, 0);
    wave(35, "dis_ch3", 3, 16'b0, 13, 0);
    wave(35, "dis_stb", 2, STB ? 16'b0100000000000 : 16'b0, 13, 2);
    goto(36);
    en = 4'b0011;

    // ch2 at 2/2, ch3 at 5/5, sync pulsed while both are low.
    goto(47);
    cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_high = 16'd2; cfg_low = 16'd2;
    goto(48);
    cfg_chan = 2'd3; cfg_high = 16'd5; cfg_low = 16'd5;
    push(48, "sync_rdy_ch3", 1, 4'h1, 4'h1);
    goto(49);
    cfg_valid = 1'b0;
    goto(50);
    en = 4'b1111;
    wave(51, "sync_ch2", 2, 16'b1100110110, 10, 0);
    wave(51, "sync_ch3", 3, 16'b1111100111, 10, 0);
    goto(57);
    sync = 1'b1;
    goto(58);
    sync = 1'b0;

    // Asynchronous reset while ch3 is mid-HIGH.
    goto(61);
    rst_n = 1'b0;
    push(61, "arst_clk", 0, 4'hF, 4'h0);
    push(61, "arst_stb", 2, 4'hF, 4'h0);
    goto(63);
    rst_n = 1'b1;
    push(63, "arst_rdy", 1, 4'h1, 4'h1);
    push(63, "arst_clk_rel", 0, 4'hF, 4'h0);
    goto(66);
    en = '0;

    if (sb.size() != 0) begin
      n_bad += sb.size();
      $display("FAIL leftover: got %0d unchecked entries expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
